// File: rtl/xdma_finish_tracker.sv
// Tracks in-flight chained-DMA tasks from allocation until their finish has been
// reported to the frontend or forwarded to the previous hop.
module xdma_finish_tracker #(
  parameter int NumEntries    = 4,
  parameter int IdWidth       = 8,
  parameter int AddrWidth     = 64,
  parameter int TimeoutCycles = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 alloc_valid_i,
  output logic                 alloc_ready_o,
  input  logic [1:0]           alloc_role_i,
  input  logic [IdWidth-1:0]   alloc_id_i,
  input  logic [AddrWidth-1:0] alloc_addr_i,
  input  logic                 local_done_valid_i,
  input  logic [IdWidth-1:0]   local_done_id_i,
  input  logic                 from_remote_finish_valid_i,
  input  logic [IdWidth-1:0]   from_remote_finish_id_i,
  output logic                 from_remote_finish_ready_o,
  output logic                 to_remote_finish_valid_o,
  input  logic                 to_remote_finish_ready_i,
  output logic [AddrWidth-1:0] remote_addr_o,
  output logic [IdWidth-1:0]   to_remote_dma_id_o,
  output logic                 xdma_finish_o,
  output logic [IdWidth-1:0]   xdma_finish_id_o,
  output logic                 xdma_write_finish_o,
  output logic                 unmatched_o,
  output logic                 timeout_o,
  input  logic                 timeout_clear_i,
  output logic                 busy_o
);

  localparam int IdxW = (NumEntries > 1) ? $clog2(NumEntries) : 1;
  localparam int CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] ToVal = CntW'(TimeoutCycles);

  typedef enum logic [2:0] {
    S_FREE, S_WAIT_LOCAL, S_WAIT_REMOTE, S_SEND_PREV, S_REPORT
  } state_e;

  localparam logic [1:0] R_READ     = 2'd0;
  localparam logic [1:0] R_FIRST_WR = 2'd1;
  localparam logic [1:0] R_MID_WR   = 2'd2;
  localparam logic [1:0] R_LAST_WR  = 2'd3;

  state_e                state_q [NumEntries];
  state_e                state_d [NumEntries];
  logic [1:0]            role_q  [NumEntries];
  logic [IdWidth-1:0]    id_q    [NumEntries];
  logic [AddrWidth-1:0]  addr_q  [NumEntries];
  logic [CntW-1:0]       cnt_q   [NumEntries];
  logic [CntW-1:0]       cnt_d   [NumEntries];
  logic                  flag_q  [NumEntries];
  logic                  flag_d  [NumEntries];

  logic            free_found, id_hit, rep_found, sp_found, any_busy, any_flag;
  logic [IdxW-1:0] free_idx, rep_idx, sp_idx, send_idx;
  logic            lock_vld_q;
  logic [IdxW-1:0] lock_idx_q;
  logic            send_pend, rep_fw, to_valid, send_hs, alloc_hs, remote_hit;

  // Priority selection on registered state only
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    id_hit     = 1'b0;
    rep_found  = 1'b0;
    rep_idx    = '0;
    sp_found   = 1'b0;
    sp_idx     = '0;
    any_busy   = 1'b0;
    any_flag   = 1'b0;
    for (int i = 0; i < NumEntries; i++) begin
      if (state_q[i] == S_FREE) begin
        if (!free_found) begin
          free_found = 1'b1;
          free_idx   = IdxW'(i);
        end
      end else begin
        any_busy = 1'b1;
        if (id_q[i] == alloc_id_i) id_hit = 1'b1;
      end
      if (state_q[i] == S_REPORT && !rep_found) begin
        rep_found = 1'b1;
        rep_idx   = IdxW'(i);
      end
      if (state_q[i] == S_SEND_PREV && !sp_found) begin
        sp_found = 1'b1;
        sp_idx   = IdxW'(i);
      end
      if (flag_q[i]) any_flag = 1'b1;
    end
  end

  // Once offered, the forwarded finish stays pinned to one entry until accepted
  assign send_idx  = lock_vld_q ? lock_idx_q : sp_idx;
  assign send_pend = lock_vld_q | sp_found;
  assign rep_fw    = rep_found && (role_q[rep_idx] == R_FIRST_WR);
  assign to_valid  = send_pend && !rep_fw;
  assign send_hs   = to_valid && to_remote_finish_ready_i;
  assign alloc_hs  = alloc_valid_i && alloc_ready_o;

  assign alloc_ready_o              = free_found && !id_hit;
  assign from_remote_finish_ready_o = 1'b1;
  assign to_remote_finish_valid_o   = to_valid;
  assign remote_addr_o              = to_valid ? addr_q[send_idx] : '0;
  assign to_remote_dma_id_o         = to_valid ? id_q[send_idx] : '0;
  assign xdma_finish_o              = rep_found;
  assign xdma_finish_id_o           = rep_found ? id_q[rep_idx] : '0;
  assign xdma_write_finish_o        = rep_fw || (send_hs && role_q[send_idx] == R_MID_WR);
  assign unmatched_o                = from_remote_finish_valid_i && !remote_hit;
  assign timeout_o                  = any_flag;
  assign busy_o                     = any_busy;

  always_comb begin
    remote_hit = 1'b0;
    for (int i = 0; i < NumEntries; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      flag_d[i]  = flag_q[i];
      case (state_q[i])
        S_FREE: begin
          if (alloc_hs && free_idx == IdxW'(i)) begin
            state_d[i] = (alloc_role_i == R_READ || alloc_role_i == R_LAST_WR) ?
                         S_WAIT_LOCAL : S_WAIT_REMOTE;
            cnt_d[i]   = '0;
          end
        end
        S_WAIT_LOCAL: begin
          if (local_done_valid_i && id_q[i] == local_done_id_i)
            state_d[i] = (role_q[i] == R_READ) ? S_REPORT : S_SEND_PREV;
        end
        S_WAIT_REMOTE: begin
          if (from_remote_finish_valid_i && id_q[i] == from_remote_finish_id_i) begin
            remote_hit = 1'b1;
            state_d[i] = (role_q[i] == R_FIRST_WR) ? S_REPORT : S_SEND_PREV;
          end
        end
        S_SEND_PREV: begin
          if (send_hs && send_idx == IdxW'(i)) state_d[i] = S_FREE;
        end
        S_REPORT: begin
          if (rep_idx == IdxW'(i)) state_d[i] = S_FREE;
        end
        default: state_d[i] = S_FREE;
      endcase
      if (TimeoutCycles > 0) begin
        if ((state_q[i] == S_WAIT_LOCAL || state_q[i] == S_WAIT_REMOTE) && cnt_q[i] != ToVal) begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
          if (cnt_q[i] + CntW'(1) == ToVal) flag_d[i] = 1'b1;
        end
        if (timeout_clear_i) begin
          cnt_d[i]  = '0;
          flag_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_vld_q <= 1'b0;
      lock_idx_q <= '0;
      for (int i = 0; i < NumEntries; i++) begin
        state_q[i] <= S_FREE;
        role_q[i]  <= '0;
        id_q[i]    <= '0;
        addr_q[i]  <= '0;
        cnt_q[i]   <= '0;
        flag_q[i]  <= 1'b0;
      end
    end else begin
      if (send_hs) begin
        lock_vld_q <= 1'b0;
      end else if (to_valid) begin
        lock_vld_q <= 1'b1;
        lock_idx_q <= send_idx;
      end
      for (int i = 0; i < NumEntries; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        flag_q[i]  <= flag_d[i];
      end
      if (alloc_hs) begin
        role_q[free_idx] <= alloc_role_i;
        id_q[free_idx]   <= alloc_id_i;
        addr_q[free_idx] <= alloc_addr_i;
      end
    end
  end

endmodule

// File: tb/tb_xdma_finish_tracker.sv
// Directed bench for xdma_finish_tracker: allocation, local/remote completion,
// forwarding backpressure, report priority, timeout and mid-task reset.
module tb_xdma_finish_tracker;
  logic        clk = 1'b0;
  logic        rst_ni;
  logic        alloc_valid, alloc_ready;
  logic [1:0]  alloc_role;
  logic [7:0]  alloc_id;
  logic [63:0] alloc_addr;
  logic        ld_valid;
  logic [7:0]  ld_id;
  logic        rf_valid, rf_ready;
  logic [7:0]  rf_id;
  logic        to_valid, to_ready;
  logic [63:0] raddr;
  logic [7:0]  rid;
  logic        fin;
  logic [7:0]  fin_id;
  logic        wfin, unmatched, tmo, tmo_clr, busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  xdma_finish_tracker #(.NumEntries(4), .IdWidth(8), .AddrWidth(64), .TimeoutCycles(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready), .alloc_role_i(alloc_role),
    .alloc_id_i(alloc_id), .alloc_addr_i(alloc_addr),
    .local_done_valid_i(ld_valid), .local_done_id_i(ld_id),
    .from_remote_finish_valid_i(rf_valid), .from_remote_finish_id_i(rf_id),
    .from_remote_finish_ready_o(rf_ready),
    .to_remote_finish_valid_o(to_valid), .to_remote_finish_ready_i(to_ready),
    .remote_addr_o(raddr), .to_remote_dma_id_o(rid),
    .xdma_finish_o(fin), .xdma_finish_id_o(fin_id), .xdma_write_finish_o(wfin),
    .unmatched_o(unmatched), .timeout_o(tmo), .timeout_clear_i(tmo_clr), .busy_o(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    alloc_valid = 1'b0; alloc_role = 2'd0; alloc_id = 8'd0; alloc_addr = 64'd0;
    ld_valid = 1'b0; ld_id = 8'd0; rf_valid = 1'b0; rf_id = 8'd0;
    to_ready = 1'b0; tmo_clr = 1'b0;
  endtask

  task automatic alloc(input logic [1:0] role, input logic [7:0] id, input logic [63:0] addr);
    alloc_valid = 1'b1; alloc_role = role; alloc_id = id; alloc_addr = addr;
    settle();
    chk("alloc_ready", alloc_ready, 1'b1);
    cyc();
    alloc_valid = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst_ni = 1'b0;
    #2;
    chk("rst_alloc_ready", alloc_ready, 1'b1);
    chk("rst_rf_ready", rf_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_finish", fin, 1'b0);
    chk("rst_to_valid", to_valid, 1'b0);
    chk("rst_timeout", tmo, 1'b0);
    repeat (2) cyc();
    rst_ni = 1'b1;
    cyc();

    // Read task completed locally; a non-matching done first is ignored
    alloc(2'd0, 8'd5, 64'h0);
    ld_valid = 1'b1; ld_id = 8'd6;
    cyc();
    ld_valid = 1'b0;
    settle();
    chk("rd_nomatch_fin", fin, 1'b0);
    chk("rd_nomatch_busy", busy, 1'b1);
    ld_valid = 1'b1; ld_id = 8'd5;
    settle();
    chk("rd_done_cycle_fin", fin, 1'b0);
    cyc();
    ld_valid = 1'b0;
    settle();
    chk("rd_fin", fin, 1'b1);
    chk("rd_fin_id", fin_id, 8'd5);
    chk("rd_no_wfin", wfin, 1'b0);
    cyc();
    chk("rd_fin_after", fin, 1'b0);
    chk("rd_fin_id_idle", fin_id, 8'd0);
    chk("rd_busy_after", busy, 1'b0);

    // MiddleWrite forwarded under backpressure
    alloc(2'd2, 8'd7, 64'h1000);
    rf_valid = 1'b1; rf_id = 8'd7;
    settle();
    chk("mw_rf_matched", unmatched, 1'b0);
    cyc();
    rf_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("mw_hold_valid", to_valid, 1'b1);
      chk("mw_hold_addr", raddr, 64'h1000);
      chk("mw_hold_id", rid, 8'd7);
      chk("mw_hold_no_wfin", wfin, 1'b0);
      cyc();
    end
    to_ready = 1'b1;
    settle();
    chk("mw_hs_valid", to_valid, 1'b1);
    chk("mw_hs_wfin", wfin, 1'b1);
    cyc();
    to_ready = 1'b0;
    settle();
    chk("mw_after_valid", to_valid, 1'b0);
    chk("mw_after_addr", raddr, 64'h0);
    chk("mw_after_wfin", wfin, 1'b0);
    chk("mw_after_busy", busy, 1'b0);

    // Remote finish with no owner
    rf_valid = 1'b1; rf_id = 8'd9;
    settle();
    chk("um_pulse", unmatched, 1'b1);
    chk("um_ready", rf_ready, 1'b1);
    cyc();
    rf_valid = 1'b0;
    settle();
    chk("um_after", unmatched, 1'b0);
    chk("um_busy", busy, 1'b0);

    // Fill all entries, then id-collision rejection
    for (int k = 1; k <= 4; k++) alloc(2'd0, 8'(k), 64'h0);
    alloc_valid = 1'b1; alloc_id = 8'd5;
    settle();
    chk("full_ready", alloc_ready, 1'b0);
    alloc_valid = 1'b0;
    ld_valid = 1'b1; ld_id = 8'd1;
    cyc();
    ld_valid = 1'b0;
    settle();
    chk("full_free_fin", fin, 1'b1);
    chk("full_free_fin_id", fin_id, 8'd1);
    cyc();
    alloc_valid = 1'b1; alloc_id = 8'd2;
    settle();
    chk("dup_id_ready", alloc_ready, 1'b0);
    alloc_valid = 1'b0;
    // Done in the same cycle as the alloc must not complete the new task
    alloc_valid = 1'b1; alloc_role = 2'd0; alloc_id = 8'd8;
    ld_valid = 1'b1; ld_id = 8'd8;
    settle();
    chk("same_cyc_ready", alloc_ready, 1'b1);
    cyc();
    alloc_valid = 1'b0; ld_valid = 1'b0;
    settle();
    chk("same_cyc_fin", fin, 1'b0);
    cyc();
    chk("same_cyc_fin2", fin, 1'b0);
    for (int k = 0; k < 4; k++) begin
      ld_valid = 1'b1;
      ld_id = (k == 3) ? 8'd8 : 8'(k + 2);
      cyc();
    end
    ld_valid = 1'b0;
    repeat (3) cyc();
    chk("fill_drained", busy, 1'b0);

    // FirstWrite report collides with a pending MiddleWrite forward
    alloc(2'd2, 8'd4, 64'h2000);
    alloc(2'd1, 8'd3, 64'h0);
    rf_valid = 1'b1; rf_id = 8'd4;
    cyc();
    rf_id = 8'd3;
    settle();
    chk("col_sp_valid", to_valid, 1'b1);
    cyc();
    rf_valid = 1'b0;
    to_ready = 1'b1;
    settle();
    chk("col_fin", fin, 1'b1);
    chk("col_fin_id", fin_id, 8'd3);
    chk("col_wfin1", wfin, 1'b1);
    chk("col_valid_held0", to_valid, 1'b0);
    cyc();
    chk("col_fin_gone", fin, 1'b0);
    chk("col_valid", to_valid, 1'b1);
    chk("col_addr", raddr, 64'h2000);
    chk("col_id", rid, 8'd4);
    chk("col_wfin2", wfin, 1'b1);
    cyc();
    to_ready = 1'b0;
    settle();
    chk("col_wfin_off", wfin, 1'b0);
    chk("col_busy", busy, 1'b0);

    // Timeout on an idle FirstWrite
    tmo_clr = 1'b1;
    cyc();
    tmo_clr = 1'b0;
    chk("to_cleared_init", tmo, 1'b0);
    alloc(2'd1, 8'd3, 64'h0);
    repeat (15) cyc();
    chk("to_before", tmo, 1'b0);
    cyc();
    chk("to_set", tmo, 1'b1);
    rf_valid = 1'b1; rf_id = 8'd3;
    cyc();
    rf_valid = 1'b0;
    settle();
    chk("to_late_fin", fin, 1'b1);
    chk("to_late_wfin", wfin, 1'b1);
    chk("to_sticky", tmo, 1'b1);
    tmo_clr = 1'b1;
    cyc();
    tmo_clr = 1'b0;
    chk("to_clear", tmo, 1'b0);
    chk("to_busy", busy, 1'b0);

    // Reset in the middle of a forward
    alloc(2'd3, 8'd9, 64'h3000);
    ld_valid = 1'b1; ld_id = 8'd9;
    cyc();
    ld_valid = 1'b0;
    settle();
    chk("rst_mid_valid", to_valid, 1'b1);
    chk("rst_mid_addr", raddr, 64'h3000);
    rst_ni = 1'b0;
    settle();
    chk("rst_mid_to_valid", to_valid, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_wfin", wfin, 1'b0);
    chk("rst_mid_ready", alloc_ready, 1'b1);
    cyc();
    rst_ni = 1'b1;
    cyc();
    chk("rst_post_valid", to_valid, 1'b0);
    chk("rst_post_fin", fin, 1'b0);
    chk("rst_post_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
